// File: rtl/addsub_pkg.sv
// Shared types and constants for the iterative adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/addsub_iter_if.sv
// Operand/result handshake bundle of addsub_iter.
interface addsub_iter_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module addsub_chunk #(
  parameter int CHUNK = 16
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] full_s;

  assign full_s = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign sum    = full_s[CHUNK-1:0];
  assign cout   = full_s[CHUNK];

endmodule

// File: rtl/addsub_iter.sv
// Multi-cycle add/sub: one CHUNK-bit slice walks the operands LSB chunk first,
// carrying between cycles in a register; flags are produced with the last chunk.
module addsub_iter
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_iter_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("addsub_iter: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bx_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;

  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] bx_chunk_s;
  logic [CHUNK-1:0] sum_s;
  logic             carry_s;
  logic [WIDTH-1:0] s_next_s;

  // Select the operand chunks addressed by the chunk counter.
  always_comb begin
    a_chunk_s  = '0;
    bx_chunk_s = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      a_chunk_s  = a_chunk_s  | ((cnt_r == CNT_W'(i)) ? a_r[i*CHUNK +: CHUNK]  : {CHUNK{1'b0}});
      bx_chunk_s = bx_chunk_s | ((cnt_r == CNT_W'(i)) ? bx_r[i*CHUNK +: CHUNK] : {CHUNK{1'b0}});
    end
  end

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .cin  (carry_r),
    .x    (a_chunk_s),
    .y    (bx_chunk_s),
    .sum  (sum_s),
    .cout (carry_s)
  );

  // Result with the current chunk merged in; flags are taken from this on the last chunk.
  always_comb begin
    s_next_s = s_r;
    for (int i = 0; i < NCHUNK; i++) begin
      s_next_s[i*CHUNK +: CHUNK] = (cnt_r == CNT_W'(i)) ? sum_s : s_r[i*CHUNK +: CHUNK];
    end
  end

  // Control FSM, operand latches and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      bx_r    <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            bx_r    <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
            carry_r <= bus.mode;
            cnt_r   <= '0;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          s_r     <= s_next_s;
          carry_r <= carry_s;
          if (cnt_r == LAST_CNT) begin
            cout_r  <= carry_s;
            ovf_r   <= (a_r[WIDTH-1] == bx_r[WIDTH-1]) && (s_next_s[WIDTH-1] != a_r[WIDTH-1]);
            zero_r  <= (s_next_s == {WIDTH{1'b0}});
            neg_r   <= s_next_s[WIDTH-1];
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.s         = s_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
  assign bus.neg       = neg_r;

endmodule

// File: tb/tb_addsub_iter.sv
// Scoreboard bench: three addsub_iter instances (CHUNK 16, 64, 1) share the stimulus;
// each has its own queue of expected results popped on its output handshake.
module tb_addsub_iter;
  import addsub_pkg::*;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    int          acc;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        mode      = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a         = 64'd0;
  logic [63:0] b         = 64'd0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [63:0] s_o [3];
  logic        ov [3];
  logic        ir [3];
  logic        co [3];
  logic        of [3];
  logic        zo [3];
  logic        ng [3];
  logic        ov_prev [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t last_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CH = (k == 0) ? 16 : ((k == 1) ? 64 : 1);
    addsub_iter_if #(.WIDTH(64)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.mode      = mode;
    assign bus.out_ready = out_ready;
    assign s_o[k]        = bus.s;
    assign ov[k]         = bus.out_valid;
    assign ir[k]         = bus.in_ready;
    assign co[k]         = bus.cout;
    assign of[k]         = bus.ovf;
    assign zo[k]         = bus.zero;
    assign ng[k]         = bus.neg;

    addsub_iter #(.WIDTH(64), .CHUNK(CH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 64;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qhead(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(input int k);
    case (k)
      0:       q0.delete(0);
      1:       q1.delete(0);
      default: q2.delete(0);
    endcase
  endfunction

  // Reference: plain wide arithmetic, carry/borrow and overflow from operand signs.
  function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb, input logic mm);
    exp_t        e;
    logic [64:0] r;
    if (mm == MODE_SUB) begin
      r      = {1'b0, ma} - {1'b0, mb};
      e.cout = (ma >= mb);
      e.ovf  = (ma[63] != mb[63]) && (r[63] != ma[63]);
    end else begin
      r      = {1'b0, ma} + {1'b0, mb};
      e.cout = r[64];
      e.ovf  = (ma[63] == mb[63]) && (r[63] != ma[63]);
    end
    e.s    = r[63:0];
    e.zero = (e.s == 64'd0);
    e.neg  = e.s[63];
    e.acc  = 0;
    return e;
  endfunction

  // Output monitor: latency on each out_valid rise, result/flags on each handshake.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst_n && ov[k] && !ov_prev[k]) begin
        if (qsize(k) == 0) begin
          chk($sformatf("spurious_valid_d%0d", k), 64'(ov[k]), 64'd0);
        end else begin
          e = qhead(k);
          chk($sformatf("latency_d%0d", k), 64'(cyc - e.acc), 64'(lat_of(k)));
        end
      end
      if (rst_n && ov[k] && out_ready && (qsize(k) != 0)) begin
        e = qhead(k);
        qpop(k);
        chk($sformatf("s_d%0d", k),    s_o[k],      e.s);
        chk($sformatf("cout_d%0d", k), 64'(co[k]),  64'(e.cout));
        chk($sformatf("ovf_d%0d", k),  64'(of[k]),  64'(e.ovf));
        chk($sformatf("zero_d%0d", k), 64'(zo[k]),  64'(e.zero));
        chk($sformatf("neg_d%0d", k),  64'(ng[k]),  64'(e.neg));
      end
      ov_prev[k] = ov[k];
    end
  end

  task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic im);
    exp_t e;
    int   t = 0;
    while (!(ir[0] && ir[1] && ir[2]) && (t < 300)) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("issue_ready", 64'(ir[0] && ir[1] && ir[2]), 64'd1);
    a        = ia;
    b        = ib;
    mode     = im;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = {$urandom(), $urandom()};
    b        = {$urandom(), $urandom()};
    mode     = ~im;
    e        = model(ia, ib, im);
    e.acc    = cyc;
    q0.push_back(e);
    q1.push_back(e);
    q2.push_back(e);
    last_e   = e;
  endtask

  task automatic drain();
    int t = 0;
    while (((qsize(0) + qsize(1) + qsize(2)) != 0 || !(ir[0] && ir[1] && ir[2])) && (t < 400)) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_done", 64'(qsize(0) + qsize(1) + qsize(2)), 64'd0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("held_s_d%0d", k),    s_o[k],     last_e.s);
      chk($sformatf("held_cout_d%0d", k), 64'(co[k]), 64'(last_e.cout));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   t;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_s_d%0d", k),     s_o[k], 64'd0);
      chk($sformatf("rst_flags_d%0d", k), 64'({co[k], of[k], zo[k], ng[k]}), 64'd0);
      chk($sformatf("rst_valid_d%0d", k), 64'(ov[k]), 64'd0);
      chk($sformatf("rst_ready_d%0d", k), 64'(ir[k]), 64'd1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(64'd2, 64'd3, MODE_ADD);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, MODE_ADD);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, MODE_ADD);
    issue(64'd5, 64'd7, MODE_SUB);
    issue(64'h8000_0000_0000_0000, 64'd1, MODE_SUB);
    issue(64'h0000_0000_FFFF_0000, 64'h0000_0000_FFFF_0000, MODE_SUB);
    for (int i = 0; i < 4; i++) begin
      issue({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    end
    drain();

    // Backpressure: result and flags must hold while out_ready stays low.
    out_ready = 1'b0;
    issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, MODE_ADD);
    e = last_e;
    t = 0;
    while (!(ov[0] && ov[1] && ov[2]) && (t < 200)) begin
      @(posedge clk);
      #1;
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = {$urandom(), $urandom()};
      b        = {$urandom(), $urandom()};
      mode     = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("bp_s_d%0d", k),     s_o[k],     e.s);
        chk($sformatf("bp_ovf_d%0d", k),   64'(of[k]), 64'(e.ovf));
        chk($sformatf("bp_neg_d%0d", k),   64'(ng[k]), 64'(e.neg));
        chk($sformatf("bp_valid_d%0d", k), 64'(ov[k]), 64'd1);
        chk($sformatf("bp_ready_d%0d", k), 64'(ir[k]), 64'd0);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset while the slow instances are computing and the fast one waits in DONE.
    out_ready = 1'b0;
    issue(64'd100, 64'd200, MODE_SUB);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_s_d%0d", k),     s_o[k], 64'd0);
      chk($sformatf("abort_flags_d%0d", k), 64'({co[k], of[k], zo[k], ng[k]}), 64'd0);
      chk($sformatf("abort_valid_d%0d", k), 64'(ov[k]), 64'd0);
      chk($sformatf("abort_ready_d%0d", k), 64'(ir[k]), 64'd1);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_abort_valid_d%0d", k), 64'(ov[k]), 64'd0);
    end

    issue(64'h8000_0000_0000_0000, 64'd1, MODE_SUB);
    issue(64'd40, 64'd2, MODE_ADD);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
